pc_branch_unit: RTL

//  Fetch-side program counter and branch resolver for the 8-bit core.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/branch_lut.sv | 31 +++
 rtl/pc_branch_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : cpu_pkg
//  Brief   : Shared types and constants for the 8-bit core fetch path.
//  Rev     : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int CPU_PC_W      = 10;
    localparam int CPU_LUT_IDX_W = 4;
    localparam int CPU_LUT_DEPTH = 2 ** CPU_LUT_IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_t;

    // Absolute branch/jump targets, indexed by the instruction's LUT field.
    localparam logic [CPU_PC_W-1:0] BRANCH_LUT [CPU_LUT_DEPTH] = '{
        10'd100,  10'd200,  10'd20,   10'd40,
        10'd512,  10'd15,   10'd1000, 10'd7,
        10'd1023, 10'd64,   10'd128,  10'd256,
        10'd33,   10'd999,  10'd500,  10'd1022
    };

    function automatic logic [CPU_PC_W-1:0] lut_entry(input logic [31:0] idx);
        logic [CPU_PC_W-1:0] v;
        v = '0;
        if (idx < 32'(CPU_LUT_DEPTH)) begin
            v = BRANCH_LUT[idx[CPU_LUT_IDX_W-1:0]];
        end
        return v;
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/branch_lut.sv
`default_nettype none
// ============================================================================
//  Module  : branch_lut
//  Brief   : Combinational branch-target lookup, lut_idx -> absolute target.
//  Rev     : 1.0  initial release
// ============================================================================
module branch_lut
    import cpu_pkg::*;
#(
    parameter int PC_W      = CPU_PC_W,
    parameter int LUT_IDX_W = CPU_LUT_IDX_W
) (
    input  logic [LUT_IDX_W-1:0] lut_idx,
    output logic [PC_W-1:0]      target
);

    localparam int C_DEPTH = 2 ** LUT_IDX_W;

    logic [PC_W-1:0] w_table [C_DEPTH];

    // Entries beyond the package table read as zero if the index is widened.
    generate
        for (genvar gi = 0; gi < C_DEPTH; gi++) begin : g_entry
            assign w_table[gi] = PC_W'(lut_entry(32'(gi)));
        end
    endgenerate

    assign target = w_table[lut_idx];

endmodule : branch_lut
`default_nettype wire

// File: rtl/pc_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module  : pc_branch_unit
//  Brief   : Fetch-side program counter, branch resolver and run/done FSM.
//  Rev     : 1.0  initial release
// ============================================================================
module pc_branch_unit
    import cpu_pkg::*;
#(
    parameter int PC_W      = CPU_PC_W,
    parameter int LUT_IDX_W = CPU_LUT_IDX_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stall,
    input  logic                 branch_en,
    input  logic                 branch_ne,
    input  logic                 jump_en,
    input  logic                 halt,
    input  logic [LUT_IDX_W-1:0] lut_idx,
    input  logic                 alu_zero,
    output logic [PC_W-1:0]      pc,
    output logic                 running,
    output logic                 done
);

    localparam logic [PC_W-1:0] C_PC_MAX = '1;

    pc_state_t       r_state;
    pc_state_t       w_next_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_next_pc;
    logic [PC_W-1:0] w_target;
    logic            w_taken;
    logic            r_running;
    logic            r_done;

    branch_lut #(
        .PC_W      (PC_W),
        .LUT_IDX_W (LUT_IDX_W)
    ) u_branch_lut (
        .lut_idx (lut_idx),
        .target  (w_target)
    );

    assign w_taken = branch_ne ? ~alu_zero : alu_zero;

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        case (r_state)
            IDLE: begin
                w_next_pc = '0;
                if (start) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (stall) begin
                    w_next_pc = r_pc;
                end else if (halt) begin
                    w_next_state = DONE;
                end else if (jump_en || (branch_en && w_taken)) begin
                    w_next_pc = w_target;
                end else if (r_pc == C_PC_MAX) begin
                    // Running off the end of instruction memory stops rather than wrapping.
                    w_next_state = DONE;
                end else begin
                    w_next_pc = r_pc + 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    w_next_state = RUN;
                    w_next_pc    = '0;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_pc    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pc      <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_pc      <= w_next_pc;
            r_running <= (w_next_state == RUN);
            r_done    <= (w_next_state == DONE);
        end
    end

    assign pc      = r_pc;
    assign running = r_running;
    assign done    = r_done;

endmodule : pc_branch_unit
`default_nettype wire
